// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared width codes, FSM encodings and bus types for mem_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam logic [1:0] c_MEM_BYTE = 2'd0;
    localparam logic [1:0] c_MEM_HALF = 2'd1;
    localparam logic [1:0] c_MEM_WORD = 2'd2;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    localparam logic [31:0] c_ZERO_WORD = 32'h0000_0000;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    // Width code 3 is treated as a full word, same as c_MEM_WORD.
    function automatic logic [2:0] width_to_bytes(input logic [1:0] width);
        case (width)
            c_MEM_BYTE: return 3'd1;
            c_MEM_HALF: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_ctrl_byte_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mem_byte_seq
//  Description : Byte index counter, RAM address generation and little-endian
//                word assembly/disassembly for one serialised access.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_seq
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_is_write,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [2:0]        i_nbytes,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [7:0]        i_ram_rdata,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [7:0]        o_ram_wdata,
    output logic              o_last,
    output logic [DATA_W-1:0] o_word
);

    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_idx;
    logic [2:0]        r_n;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_asm;

    logic              w_last;
    logic [2:0]        w_prev;
    logic [DATA_W-1:0] w_merged;

    // Reads need one extra cycle (index n) to capture the final RAM byte.
    assign w_last   = r_wr ? (r_idx == (r_n - 3'd1)) : (r_idx == r_n);
    assign w_prev   = r_idx - 3'd1;
    assign w_merged = r_asm | ({{(DATA_W-8){1'b0}}, i_ram_rdata} << {w_prev[1:0], 3'b000});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base  <= '0;
            r_idx   <= '0;
            r_n     <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_asm   <= '0;
        end else if (i_start) begin
            r_base  <= i_base;
            r_idx   <= '0;
            r_n     <= i_nbytes;
            r_wr    <= i_is_write;
            r_wdata <= i_wdata;
            r_asm   <= '0;
        end else if (i_step) begin
            // Index freezes on the last cycle so the RAM address holds afterwards.
            if (!w_last)
                r_idx <= r_idx + 3'd1;
            if (!r_wr && (r_idx != 3'd0))
                r_asm <= w_merged;
        end
    end

    assign o_ram_addr  = r_base + ADDR_W'(r_idx);
    assign o_ram_wdata = r_wdata[{r_idx[1:0], 3'b000} +: 8];
    assign o_last      = w_last;
    assign o_word      = w_merged;

endmodule : mem_byte_seq
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Arbitrates IF and MEM requests onto a byte-wide synchronous
//                RAM. Optional IF word buffer: MEM_CTRL_IF_BUFFER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_r_enable_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_busy_o,
    output logic              if_done_o,
    input  logic              mem_r_enable_i,
    input  logic              mem_w_enable_i,
    input  logic [1:0]        mem_width_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_busy_o,
    output logic              mem_done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_wdata_o,
    output logic              ram_we_o,
    input  logic [7:0]        ram_rdata_i
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_port_mem;
    logic              r_is_write;
    logic              r_if_armed;
    logic              r_mem_armed;
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] r_mem_rdata;

    logic              w_idle;
    logic              w_mem_req;
    logic              w_mem_accept;
    logic              w_if_accept;
    logic              w_if_hit;
    logic              w_start;
    logic              w_mem_wr_accept;
    logic              w_rd_finish;
    logic              w_seq_last;
    logic [DATA_W-1:0] w_seq_word;
    logic [ADDR_W-1:0] w_start_addr;
    logic [2:0]        w_start_n;

    assign w_idle          = (r_state == c_ST_IDLE);
    assign w_mem_req       = mem_r_enable_i | mem_w_enable_i;
    // MEM wins arbitration; a losing IF request stays armed and pending.
    assign w_mem_accept    = w_idle & r_mem_armed & w_mem_req;
    assign w_if_accept     = w_idle & r_if_armed & if_r_enable_i & ~w_mem_accept;
    assign w_mem_wr_accept = w_mem_accept & mem_w_enable_i;
    assign w_start         = w_mem_accept | (w_if_accept & ~w_if_hit);
    assign w_rd_finish     = (r_state == c_ST_ACCESS) & ~r_is_write & w_seq_last;
    assign w_start_addr    = w_mem_accept ? mem_addr_i : if_addr_i;
    assign w_start_n       = w_mem_accept ? width_to_bytes(mem_width_i) : 3'd4;

`ifdef MEM_CTRL_IF_BUFFER_EN
    logic              r_buf_valid;
    logic [ADDR_W-1:0] r_buf_addr;
    logic [DATA_W-1:0] r_buf_data;
    logic [ADDR_W-1:0] r_req_addr;

    assign w_if_hit = w_if_accept & r_buf_valid & (r_buf_addr == if_addr_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
            r_req_addr  <= '0;
        end else begin
            if (w_mem_accept | w_if_accept)
                r_req_addr <= w_start_addr;
            if (w_mem_wr_accept) begin
                r_buf_valid <= 1'b0;
            end else if (w_rd_finish & ~r_port_mem) begin
                r_buf_valid <= 1'b1;
                r_buf_addr  <= r_req_addr;
                r_buf_data  <= w_seq_word;
            end
        end
    end
`else
    assign w_if_hit = 1'b0;
`endif

    mem_byte_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_byte_seq (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_step      (r_state == c_ST_ACCESS),
        .i_is_write  (w_mem_wr_accept),
        .i_base      (w_start_addr),
        .i_nbytes    (w_start_n),
        .i_wdata     (mem_wdata_i),
        .i_ram_rdata (ram_rdata_i),
        .o_ram_addr  (ram_addr_o),
        .o_ram_wdata (ram_wdata_o),
        .o_last      (w_seq_last),
        .o_word      (w_seq_word)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start)
                    w_state_nxt = c_ST_ACCESS;
                else if (w_if_hit)
                    w_state_nxt = c_ST_DONE;
            end
            c_ST_ACCESS: begin
                if (w_seq_last)
                    w_state_nxt = c_ST_DONE;
            end
            c_ST_DONE:   w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        if_busy_o  = (r_state != c_ST_IDLE);
        mem_busy_o = (r_state != c_ST_IDLE);
        if_done_o  = (r_state == c_ST_DONE) & ~r_port_mem;
        mem_done_o = (r_state == c_ST_DONE) &  r_port_mem;
        ram_we_o   = (r_state == c_ST_ACCESS) & r_is_write;
    end

    // Ports re-arm whenever their enable is seen low, so a held request is served once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_armed  <= 1'b1;
            r_mem_armed <= 1'b1;
            r_port_mem  <= 1'b0;
            r_is_write  <= 1'b0;
        end else begin
            if (!if_r_enable_i)
                r_if_armed <= 1'b1;
            else if (w_if_accept)
                r_if_armed <= 1'b0;

            if (!w_mem_req)
                r_mem_armed <= 1'b1;
            else if (w_mem_accept)
                r_mem_armed <= 1'b0;

            if (w_mem_accept | w_if_accept) begin
                r_port_mem <= w_mem_accept;
                r_is_write <= w_mem_wr_accept;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_data   <= DATA_W'(c_ZERO_WORD);
            r_mem_rdata <= DATA_W'(c_ZERO_WORD);
        end else begin
            if (w_rd_finish) begin
                if (r_port_mem)
                    r_mem_rdata <= w_seq_word;
                else
                    r_if_data <= w_seq_word;
            end
`ifdef MEM_CTRL_IF_BUFFER_EN
            if (w_if_hit)
                r_if_data <= r_buf_data;
`endif
        end
    end

    assign if_data_o   = r_if_data;
    assign mem_rdata_o = r_mem_rdata;

endmodule : mem_ctrl
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ctrl
//  Description : Scoreboard bench for mem_ctrl with a byte-wide RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        if_r_enable_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_busy_o;
    logic        if_done_o;
    logic        mem_r_enable_i;
    logic        mem_w_enable_i;
    logic [1:0]  mem_width_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_busy_o;
    logic        mem_done_o;
    logic [31:0] ram_addr_o;
    logic [7:0]  ram_wdata_o;
    logic        ram_we_o;
    logic [7:0]  ram_rdata_i;

    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_r_enable_i  (if_r_enable_i),
        .if_addr_i      (if_addr_i),
        .if_data_o      (if_data_o),
        .if_busy_o      (if_busy_o),
        .if_done_o      (if_done_o),
        .mem_r_enable_i (mem_r_enable_i),
        .mem_w_enable_i (mem_w_enable_i),
        .mem_width_i    (mem_width_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_rdata_o    (mem_rdata_o),
        .mem_busy_o     (mem_busy_o),
        .mem_done_o     (mem_done_o),
        .ram_addr_o     (ram_addr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_we_o       (ram_we_o),
        .ram_rdata_i    (ram_rdata_i)
    );

    typedef struct {
        logic [31:0] data;
        bit          chk_data;
        int          cyc;
    } exp_t;

    exp_t        if_q[$];
    exp_t        mem_q[$];
    logic [7:0]  ram [logic [31:0]];
    int          cyc;
    int          total;
    int          bad;
    int          if_done_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    initial begin
        ram_rdata_i = 8'h00;
        forever begin
            @(posedge clk);
            ram_rdata_i <= ram_rd(ram_addr_o);
            if (ram_we_o)
                ram[ram_addr_o] = ram_wdata_o;
        end
    end

    // Monitor: pops one expectation per completion pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_done_o) begin
                if_done_cnt++;
                total++;
                if (if_q.size() == 0) begin
                    bad++;
                    $display("FAIL if_done_unexpected: got pulse at cyc=%0d want none", cyc);
                end else begin
                    e = if_q.pop_front();
                    if ((e.chk_data && if_data_o !== e.data) || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL if_done: got data=%h cyc=%0d want data=%h cyc=%0d",
                                 if_data_o, cyc, e.data, e.cyc);
                    end
                end
            end
            if (mem_done_o) begin
                total++;
                if (mem_q.size() == 0) begin
                    bad++;
                    $display("FAIL mem_done_unexpected: got pulse at cyc=%0d want none", cyc);
                end else begin
                    e = mem_q.pop_front();
                    if ((e.chk_data && mem_rdata_o !== e.data) || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL mem_done: got data=%h cyc=%0d want data=%h cyc=%0d",
                                 mem_rdata_o, cyc, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (if_busy_o && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (if_busy_o) begin
            bad++;
            $display("FAIL wait_idle: got busy=1 want 0 after %0d cycles", n);
        end
        tick();
    endtask

    // Issue one request in the current (idle) cycle; expected done at T+lat.
    task automatic issue(input bit is_mem, input bit wr, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_d, input bit chk_d, input int lat);
        exp_t e;
        e.data = exp_d; e.chk_data = chk_d; e.cyc = cyc + lat;
        if (is_mem) begin
            mem_w_enable_i = wr;
            mem_r_enable_i = ~wr;
            mem_width_i    = w;
            mem_addr_i     = a;
            mem_wdata_i    = wd;
            mem_q.push_back(e);
        end else begin
            if_r_enable_i = 1'b1;
            if_addr_i     = a;
            if_q.push_back(e);
        end
        tick();
        if_r_enable_i  = 1'b0;
        mem_r_enable_i = 1'b0;
        mem_w_enable_i = 1'b0;
        wait_idle();
    endtask

    initial begin
        int t0;
        int cnt0;
        cyc = 0; total = 0; bad = 0; if_done_cnt = 0;
        rst = 1'b1;
        if_r_enable_i = 1'b0; if_addr_i = '0;
        mem_r_enable_i = 1'b0; mem_w_enable_i = 1'b0;
        mem_width_i = 2'd0; mem_addr_i = '0; mem_wdata_i = '0;
        ram[32'h10] = 8'h13; ram[32'h11] = 8'h00; ram[32'h12] = 8'h50; ram[32'h13] = 8'h00;
        repeat (3) tick();

        chk("rst_busy",      {31'd0, if_busy_o | mem_busy_o}, 32'd0);
        chk("rst_done",      {30'd0, if_done_o, mem_done_o}, 32'd0);
        chk("rst_we",        {31'd0, ram_we_o}, 32'd0);
        chk("rst_ram_addr",  ram_addr_o, 32'd0);
        chk("rst_ram_wdata", {24'd0, ram_wdata_o}, 32'd0);
        chk("rst_if_data",   if_data_o, 32'd0);
        chk("rst_mem_rdata", mem_rdata_o, 32'd0);
        rst = 1'b0;
        tick();

        // Instruction fetch with busy window T+1..T+6.
        t0 = cyc;
        if_r_enable_i = 1'b1; if_addr_i = 32'h10;
        if_q.push_back('{data: 32'h0050_0013, chk_data: 1'b1, cyc: t0 + 6});
        for (int k = 1; k <= 6; k++) begin
            tick();
            if_r_enable_i = 1'b0;
            chk($sformatf("fetch_busy_T+%0d", k), {31'd0, if_busy_o}, 32'd1);
        end
        tick();
        chk("fetch_busy_T+7", {31'd0, if_busy_o}, 32'd0);
        chk("fetch_data_hold", if_data_o, 32'h0050_0013);
        tick();

        // Word write then byte/half reads back.
        issue(1'b1, 1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0, 5);
        chk("ww_b0", {24'd0, ram_rd(32'h100)}, 32'hEF);
        chk("ww_b1", {24'd0, ram_rd(32'h101)}, 32'hBE);
        chk("ww_b2", {24'd0, ram_rd(32'h102)}, 32'hAD);
        chk("ww_b3", {24'd0, ram_rd(32'h103)}, 32'hDE);
        issue(1'b1, 1'b0, 2'd0, 32'h102, 32'h0, 32'h0000_00AD, 1'b1, 3);
        issue(1'b1, 1'b0, 2'd1, 32'h100, 32'h0, 32'h0000_BEEF, 1'b1, 4);
        issue(1'b1, 1'b0, 2'd3, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b1, 6);

        // Simultaneous IF and MEM read, both held high.
        t0 = cyc;
        cnt0 = if_done_cnt;
        mem_q.push_back('{data: 32'hDEAD_BEEF, chk_data: 1'b1, cyc: t0 + 6});
        if_q.push_back('{data: 32'h0050_0013, chk_data: 1'b1, cyc: t0 + 13});
        mem_r_enable_i = 1'b1; mem_width_i = 2'd2; mem_addr_i = 32'h100;
        if_r_enable_i = 1'b1; if_addr_i = 32'h10;
        repeat (25) tick();
        chk("held_if_once", if_done_cnt - cnt0, 32'd1);
        chk("held_idle", {31'd0, if_busy_o}, 32'd0);
        mem_r_enable_i = 1'b0; if_r_enable_i = 1'b0;
        tick();

        // Half write wrapping past the top of the address space.
        issue(1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h1234_A55A, 32'h0, 1'b0, 3);
        chk("wrap_b0", {24'd0, ram_rd(32'hFFFF_FFFF)}, 32'h5A);
        chk("wrap_b1", {24'd0, ram_rd(32'h0000_0000)}, 32'hA5);
        chk("wrap_addr_hold", ram_addr_o, 32'h0000_0000);
        chk("rdata_kept", mem_rdata_o, 32'hDEAD_BEEF);

        // Reset in the third ACCESS cycle of a word write.
        t0 = cyc;
        mem_w_enable_i = 1'b1; mem_width_i = 2'd2; mem_addr_i = 32'h200; mem_wdata_i = 32'hCAFE_F00D;
        tick();
        mem_w_enable_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_we", {31'd0, ram_we_o}, 32'd0);
        chk("abort_busy", {31'd0, mem_busy_o}, 32'd0);
        chk("abort_cyc", cyc - t0, 32'd4);
        rst = 1'b0;
        tick();
        chk("abort_b0", {24'd0, ram_rd(32'h200)}, 32'h0D);
        chk("abort_b2", {24'd0, ram_rd(32'h202)}, 32'hFE);
        chk("abort_b3", {24'd0, ram_rd(32'h203)}, 32'h00);
        issue(1'b0, 1'b0, 2'd0, 32'h10, 32'h0, 32'h0050_0013, 1'b1, 6);

`ifdef MEM_CTRL_IF_BUFFER_EN
        issue(1'b0, 1'b0, 2'd0, 32'h10, 32'h0, 32'h0050_0013, 1'b1, 1);
`else
        issue(1'b0, 1'b0, 2'd0, 32'h10, 32'h0, 32'h0050_0013, 1'b1, 6);
`endif
        issue(1'b1, 1'b1, 2'd0, 32'h300, 32'h0000_0077, 32'h0, 1'b0, 2);
        chk("byte_wr", {24'd0, ram_rd(32'h300)}, 32'h77);
        issue(1'b0, 1'b0, 2'd0, 32'h10, 32'h0, 32'h0050_0013, 1'b1, 6);

        repeat (3) tick();
        chk("if_q_drained", if_q.size(), 32'd0);
        chk("mem_q_drained", mem_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_ctrl
`default_nettype wire

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder side of the instruction-fetch ROM handshake (r_enable / busy / done).
- Also serves the data-memory (MEM stage) port.
- Serialises every request onto a byte-wide synchronous backing RAM and assembles/disassembles little-endian words.
- Sits between the IF and MEM pipeline stages and the board RAM/UART bridge; the only owner of the RAM bus.

Parameters:
- ADDR_W, 32, width of both request addresses and ram_addr_o.
- DATA_W, 32, word width; fixed at 32 for RV32I.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_r_enable_i  in  1  instruction read request (level)
- if_addr_i  in  ADDR_W  instruction address
- if_data_o  out  DATA_W  fetched instruction
- if_busy_o  out  1  controller busy (any port)
- if_done_o  out  1  one-cycle completion pulse, IF port
- mem_r_enable_i  in  1  data read request (level)
- mem_w_enable_i  in  1  data write request (level)
- mem_width_i  in  2  access width: 0=byte, 1=half, 2=word, 3=word
- mem_addr_i  in  ADDR_W  data address
- mem_wdata_i  in  DATA_W  write data; low bytes are used
- mem_rdata_o  out  DATA_W  read data, zero-extended
- mem_busy_o  out  1  controller busy (any port)
- mem_done_o  out  1  one-cycle completion pulse, MEM port
- ram_addr_o  out  ADDR_W  byte address to RAM
- ram_wdata_o  out  8  byte write data
- ram_we_o  out  1  byte write strobe
- ram_rdata_i  in  8  RAM read byte, valid the cycle after its address

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; both ports armed.
  - Reset mid-transaction aborts at that edge: ram_we_o low, no done pulse.
  - Partial RAM writes already issued are not undone.
- States:
  - IDLE, ACCESS, DONE.
  - busy_o (both ports) is high in ACCESS and DONE, low in IDLE.
- Arming (edge-qualified requests):
  - A port disarms on acceptance.
  - It re-arms in any cycle its enable is sampled low.
  - A request is accepted only when armed, the enable is high and state is IDLE.
  - A held enable is never served twice.
- Arbitration in IDLE: MEM port over IF port; the losing request stays pending.
  - mem_w_enable_i and mem_r_enable_i both high: treat as a write.
- Acceptance (cycle T):
  - latch address, width, wdata and port;
  - n = 1, 2 or 4 bytes (IF always 4);
  - state becomes ACCESS with byte index i=0.
- ACCESS, cycle T+1+i:
  - ram_addr_o = base + i, modulo 2^ADDR_W, so the address wraps.
  - Write: ram_we_o=1, ram_wdata_o = byte i of wdata.
  - Read: byte i is captured at T+2+i into bits [8i+7:8i].
  - After the last byte, move to DONE. Reads spend one extra ACCESS cycle (i=n) for the final capture with ram_we_o=0.
- DONE: the selected port's done_o is high for exactly one cycle, then IDLE.
  - Read done is at T+n+2; write done is at T+n+1.
  - Word fetch: done at T+6.
- Read data:
  - Latched at DONE and held stable until that port's next read completes.
  - Unread upper bytes are 0; sign extension belongs to the MEM stage.
- Misalignment is not checked; bytes are accessed sequentially from base.
- ram_addr_o holds its last value when idle; ram_we_o is 0 outside write ACCESS cycles.

Optional Feature:
- Macro: MEM_CTRL_IF_BUFFER_EN.
- Enabled: a one-entry buffer holds the last completed IF address and word, with a valid bit.
  - Hit: an accepted IF request whose address equals the buffered address, with valid set, skips ACCESS and asserts if_done_o at T+1 with the buffered word.
  - Any accepted MEM write clears valid; reset clears valid.
- Disabled: every IF request performs the full 4-byte access.

Decomposition:
- Shared header Defines.vh:
  - width codes MemByte/MemHalf/MemWord;
  - state encodings;
  - ZeroWord, InstAddrBus, InstBus.
- One sub-module, mem_byte_seq: byte index counter, address increment and the byte assemble/disassemble datapath.
- Arbitration and the FSM stay in mem_ctrl.

Test Plan:
- IF fetch at 0x00000010, RAM bytes 13 00 50 00 → if_data_o=0x00500013, if_done_o pulses at T+6, busy high T+1..T+6.
- MEM word write 0xDEADBEEF to 0x100 → RAM[0x100..0x103]=EF BE AD DE; mem_done_o at T+5; a subsequent byte read at 0x102 returns 0x000000AD.
- Simultaneous IF and MEM read in IDLE → MEM served first. IF is accepted in the first IDLE cycle after MEM's DONE. Exactly one if_done_o while if_r_enable_i stays high.
- Half write at 0xFFFFFFFF → bytes go to 0xFFFFFFFF and 0x00000000 (wrap); done at T+3.
- rst asserted at T+3 of a word write → ram_we_o low next cycle, no done, busy 0, next fetch served normally.
- With MEM_CTRL_IF_BUFFER_EN: repeat fetch of 0x10 → done at T+1. After an intervening MEM write, the fetch takes the full T+6 path.
